// File: rtl/warp_sched_pkg.sv
// Shared types and default sizing for the warp fetch scheduler.
package warp_sched_pkg;

    localparam int DEF_NUM_WARPS = 32;
    localparam int DEF_WARP_ID_W = 5;
    localparam int DEF_PC_W      = 32;
    localparam int DEF_PC_STEP   = 4;

    typedef enum logic [1:0] {
        WS_INVALID = 2'd0,
        WS_READY   = 2'd1,
        WS_PENDING = 2'd2
    } warp_state_t;

endpackage

// File: rtl/warp_fetch_scheduler_rr_arbiter.sv
// Combinational round-robin picker: first request at or after ptr, with wrap-around.
module rr_arbiter #(
    parameter int N     = 32,
    parameter int IDX_W = 5
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             any_grant,
    output logic             last
);

    logic [IDX_W-1:0] idx;
    logic             found;
    logic             higher;

    always_comb begin
        idx     = '0;
        found   = 1'b0;
        gnt_idx = '0;
        for (int i = 0; i < N; i++) begin
            // N is a power of two, so the IDX_W-bit add wraps exactly at N
            idx = ptr + IDX_W'(i);
            if (!found && req[idx]) begin
                found   = 1'b1;
                gnt_idx = idx;
            end
        end
        any_grant = found;
        gnt       = '0;
        if (found) begin
            gnt[gnt_idx] = 1'b1;
        end
    end

    // The sweep ends when nothing eligible sits above the winner
    always_comb begin
        higher = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (req[i] && (i > int'(gnt_idx))) begin
                higher = 1'b1;
            end
        end
        last = found && !higher;
    end

endmodule

// File: rtl/warp_fetch_scheduler.sv
// Per-warp PC/state tracking with a round-robin fetch request to the I-cache.
// Optional perf counters enabled by defining WARP_SCHED_PERF_CNT_EN.
module warp_fetch_scheduler
    import warp_sched_pkg::*;
#(
    parameter int NUM_WARPS = DEF_NUM_WARPS,
    parameter int WARP_ID_W = DEF_WARP_ID_W,
    parameter int PC_W      = DEF_PC_W,
    parameter int PC_STEP   = DEF_PC_STEP
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 launch_valid,
    input  logic [WARP_ID_W-1:0] launch_warp_id,
    input  logic [PC_W-1:0]      launch_pc,
    input  logic                 redirect_valid,
    input  logic [WARP_ID_W-1:0] redirect_warp_id,
    input  logic [PC_W-1:0]      redirect_pc,
    input  logic                 exit_valid,
    input  logic [WARP_ID_W-1:0] exit_warp_id,
    input  logic                 resp_valid,
    input  logic [WARP_ID_W-1:0] resp_warp_id,
    input  logic                 fetch_hold,
    output logic [WARP_ID_W-1:0] selected_warp_id,
    output logic [PC_W-1:0]      selected_pc,
    output logic                 s_tvalid,
    output logic                 s_tlast,
    output logic [NUM_WARPS-1:0] active_mask,
    output logic                 idle
`ifdef WARP_SCHED_PERF_CNT_EN
    ,
    output logic [31:0]          perf_fetch_cnt,
    output logic [31:0]          perf_stall_cnt
`endif
);

    warp_state_t          state     [NUM_WARPS];
    warp_state_t          state_nxt [NUM_WARPS];
    logic [PC_W-1:0]      pc        [NUM_WARPS];
    logic [PC_W-1:0]      pc_nxt    [NUM_WARPS];
    logic [NUM_WARPS-1:0] flush;
    logic [NUM_WARPS-1:0] flush_nxt;
    logic [NUM_WARPS-1:0] live_nxt;
    logic [NUM_WARPS-1:0] ready_vec;
    logic [NUM_WARPS-1:0] eligible;
    logic [NUM_WARPS-1:0] launch_dec;
    logic [NUM_WARPS-1:0] redir_dec;
    logic [NUM_WARPS-1:0] exit_dec;
    logic [NUM_WARPS-1:0] resp_dec;
    logic [NUM_WARPS-1:0] gnt_onehot;
    logic [WARP_ID_W-1:0] rr_ptr;
    logic [WARP_ID_W-1:0] gnt_idx;
    logic                 any_grant;
    logic                 gnt_last;

    always_comb begin
        launch_dec = NUM_WARPS'(launch_valid) << launch_warp_id;
        redir_dec  = NUM_WARPS'(redirect_valid) << redirect_warp_id;
        exit_dec   = NUM_WARPS'(exit_valid) << exit_warp_id;
        resp_dec   = NUM_WARPS'(resp_valid) << resp_warp_id;
        ready_vec  = '0;
        for (int w = 0; w < NUM_WARPS; w++) begin
            ready_vec[w] = (state[w] == WS_READY);
        end
        // A warp being redirected or retired this cycle must not fetch its stale PC
        eligible = ready_vec & ~redir_dec & ~exit_dec & {NUM_WARPS{~fetch_hold}};
    end

    rr_arbiter #(
        .N     (NUM_WARPS),
        .IDX_W (WARP_ID_W)
    ) u_rr_arbiter (
        .req       (eligible),
        .ptr       (rr_ptr),
        .gnt       (gnt_onehot),
        .gnt_idx   (gnt_idx),
        .any_grant (any_grant),
        .last      (gnt_last)
    );

    // Event priority per warp: exit > redirect > launch > response > grant
    always_comb begin
        flush_nxt = flush;
        live_nxt  = '0;
        for (int w = 0; w < NUM_WARPS; w++) begin
            state_nxt[w] = state[w];
            pc_nxt[w]    = pc[w];
            if (exit_dec[w]) begin
                state_nxt[w] = WS_INVALID;
            end else if (redir_dec[w] && state[w] != WS_INVALID) begin
                state_nxt[w] = WS_READY;
                pc_nxt[w]    = redirect_pc;
            end else if (launch_dec[w] && state[w] == WS_INVALID) begin
                state_nxt[w] = WS_READY;
                pc_nxt[w]    = launch_pc;
            end else if (resp_dec[w] && state[w] == WS_PENDING && !flush[w]) begin
                state_nxt[w] = WS_READY;
            end else if (gnt_onehot[w]) begin
                state_nxt[w] = WS_PENDING;
                pc_nxt[w]    = pc[w] + PC_W'(PC_STEP);
            end

            // The in-flight fetch of a killed warp is still owed a response; swallow it
            if ((exit_dec[w] || redir_dec[w]) && state[w] == WS_PENDING) begin
                flush_nxt[w] = 1'b1;
            end else if (resp_dec[w]) begin
                flush_nxt[w] = 1'b0;
            end

            live_nxt[w] = (state_nxt[w] != WS_INVALID);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                state[w] <= WS_INVALID;
                pc[w]    <= '0;
            end
            flush            <= '0;
            rr_ptr           <= '0;
            selected_warp_id <= '0;
            selected_pc      <= '0;
            s_tvalid         <= 1'b0;
            s_tlast          <= 1'b0;
            active_mask      <= '0;
            idle             <= 1'b1;
        end else begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                state[w] <= state_nxt[w];
                pc[w]    <= pc_nxt[w];
            end
            flush       <= flush_nxt;
            active_mask <= live_nxt;
            idle        <= ~|live_nxt;
            s_tvalid    <= any_grant;
            s_tlast     <= any_grant && gnt_last;
            if (any_grant) begin
                selected_warp_id <= gnt_idx;
                selected_pc      <= pc[gnt_idx];
                rr_ptr           <= gnt_idx + WARP_ID_W'(1);
            end
        end
    end

`ifdef WARP_SCHED_PERF_CNT_EN
    // active_mask holds the pre-update population, so it qualifies this cycle's stall
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetch_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (any_grant) begin
                perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            end else if (|active_mask) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
